// File: rtl/gp_register_file_if.sv
// Bus bundle for gp_register_file: byte/word write ports, pointer control,
// two read ports, the pointer effective address and the flat register view.
// master = core control side, slave = the register file.
interface gp_register_file_if #(
  parameter int WIDTH = 8
);
  logic                   wr_en;
  logic [4:0]             wr_addr;
  logic [WIDTH-1:0]       wr_data;
  logic                   wr_word_en;
  logic [3:0]             wr_word_addr;
  logic [2*WIDTH-1:0]     wr_word_data;
  logic [1:0]             ptr_sel;
  logic [1:0]             ptr_op;
  logic [4:0]             rd_addr_a;
  logic [4:0]             rd_addr_b;
  logic [WIDTH-1:0]       rd_data_a;
  logic [WIDTH-1:0]       rd_data_b;
  logic [2*WIDTH-1:0]     ptr_addr;
  logic [32*WIDTH-1:0]    reg_flat;

  modport master (
    output wr_en, wr_addr, wr_data, wr_word_en, wr_word_addr, wr_word_data,
    output ptr_sel, ptr_op, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, ptr_addr, reg_flat
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_word_en, wr_word_addr, wr_word_data,
    input  ptr_sel, ptr_op, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, ptr_addr, reg_flat
  );
endinterface

// File: rtl/gp_register_file.sv
// AVR general-purpose register file: 32 x WIDTH registers with a byte write
// port, a pair (word) write port and X/Y/Z pointer post-inc / pre-dec.
// Per-byte write priority: pointer update > word write > byte write.
// Optional macro GPR_WRITE_BYPASS_EN: rd_data_a/b forward the pending
// next-state value (reg_flat always shows stored state). Default build
// (macro undefined) returns stored values only.
module gp_register_file #(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             reset,
  gp_register_file_if.slave bus
);
  localparam int PW = 2 * WIDTH;

  logic [WIDTH-1:0] regs_q [32];
  logic [WIDTH-1:0] regs_d [32];

  logic [4:0]    ptr_lo_idx_s;
  logic [4:0]    ptr_hi_idx_s;
  logic [PW-1:0] ptr_cur_s;
  logic [PW-1:0] ptr_inc_s;
  logic [PW-1:0] ptr_dec_s;
  logic [PW-1:0] ptr_new_s;
  logic          ptr_active_s;

  // X=R27:R26, Y=R29:R28, Z=R31:R30 map to index 0b11_sel_b
  assign ptr_lo_idx_s = {2'b11, bus.ptr_sel, 1'b0};
  assign ptr_hi_idx_s = {2'b11, bus.ptr_sel, 1'b1};
  assign ptr_cur_s    = {regs_q[ptr_hi_idx_s], regs_q[ptr_lo_idx_s]};
  assign ptr_inc_s    = ptr_cur_s + PW'(1'b1);
  assign ptr_dec_s    = ptr_cur_s - PW'(1'b1);

  // Decode the pointer operation and the effective LD/ST address
  always_comb begin
    ptr_active_s = 1'b0;
    ptr_new_s    = ptr_cur_s;
    bus.ptr_addr = ptr_cur_s;
    if (bus.ptr_sel == 2'b00) begin
      bus.ptr_addr = {PW{1'b0}};
    end else begin
      case (bus.ptr_op)
        2'b01: begin
          ptr_active_s = 1'b1;
          ptr_new_s    = ptr_inc_s;
        end
        2'b10: begin
          ptr_active_s = 1'b1;
          ptr_new_s    = ptr_dec_s;
          bus.ptr_addr = ptr_dec_s;
        end
        default: begin
          ptr_active_s = 1'b0;
        end
      endcase
    end
  end

  // Next register state: apply writes lowest priority first so later ones win
  always_comb begin
    regs_d = regs_q;
    if (bus.wr_en) begin
      regs_d[bus.wr_addr] = bus.wr_data;
    end else begin
      regs_d[bus.wr_addr] = regs_q[bus.wr_addr];
    end
    if (bus.wr_word_en) begin
      regs_d[{bus.wr_word_addr, 1'b0}] = bus.wr_word_data[WIDTH-1:0];
      regs_d[{bus.wr_word_addr, 1'b1}] = bus.wr_word_data[PW-1:WIDTH];
    end else begin
      regs_d[{bus.wr_word_addr, 1'b0}] = regs_d[{bus.wr_word_addr, 1'b0}];
    end
    if (ptr_active_s) begin
      regs_d[ptr_lo_idx_s] = ptr_new_s[WIDTH-1:0];
      regs_d[ptr_hi_idx_s] = ptr_new_s[PW-1:WIDTH];
    end else begin
      regs_d[ptr_lo_idx_s] = regs_d[ptr_lo_idx_s];
    end
  end

  // Register storage with synchronous clear that overrides every update
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      regs_q <= regs_d;
    end
  end

`ifdef GPR_WRITE_BYPASS_EN
  // Read ports forward the resolved same-cycle write value
  always_comb begin
    bus.rd_data_a = regs_d[bus.rd_addr_a];
    bus.rd_data_b = regs_d[bus.rd_addr_b];
  end
`else
  // Read ports return stored state only
  always_comb begin
    bus.rd_data_a = regs_q[bus.rd_addr_a];
    bus.rd_data_b = regs_q[bus.rd_addr_b];
  end
`endif

  // Flat view of all stored registers, R0 in the low byte
  always_comb begin
    bus.reg_flat = {(32 * WIDTH){1'b0}};
    for (int i = 0; i < 32; i++) begin
      bus.reg_flat[i*WIDTH +: WIDTH] = regs_q[i];
    end
  end
endmodule
